ram_parity_scrubber: RTL and testbench

- Downstream consumer of the parity-extended RAM read port, run as a background integrity sweeper.
- Drives an address range into the RAM one word per cycle and checks each returned word (DATA_WIDTH data bits plus 1 parity bit) for even parity.
- Verifies that the registered address echo matches the address issued.
- Counts errors, queues failing addresses in a small FIFO for the host, and reports sweep completion.

---
 rtl/ram_parity_scrubber.sv | 174 +++++++++++++++++
 tb/tb_ram_parity_scrubber.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_parity_scrubber.sv
// Background integrity sweeper for a parity-extended RAM read port: walks an address range,
// checks even parity and the address echo of every word, and queues failing addresses.
module ram_parity_scrubber #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ERR_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] lo_addr,
  input  logic [ADDR_WIDTH-1:0] hi_addr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH:0]   ram_data_out,
  input  logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_kind,
  input  logic                  err_pop,
  output logic                  err_overflow
);

  localparam int unsigned PtrW = $clog2(ERR_DEPTH);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH-1:0] hi_q, hi_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [PtrW:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]         rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] fifo_addr_q [ERR_DEPTH];
  logic [1:0]            fifo_kind_q [ERR_DEPTH];

  logic                  check_en;
  logic                  clr_stats;
  logic                  parity_err;
  logic                  addr_err;
  logic                  word_err;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // The word on ram_data_out belongs to the address presented during the previous cycle,
  // which is still held in ram_addr_q at the checking edge.
  assign parity_err = ^ram_data_out;
  assign addr_err   = (ram_addr_out != ram_addr_q);
  assign word_err   = check_en & (parity_err | addr_err);
  assign addr_inc   = ram_addr_q + ADDR_WIDTH'(1);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = err_pop & ~fifo_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push       = word_err & (~fifo_full | pop);

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    check_en   = 1'b0;
    clr_stats  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          ram_addr_d = lo_addr;
          hi_d       = hi_addr;
          clr_stats  = 1'b1;
          state_d    = StSweep;
        end
      end
      StSweep: begin
        // Only reachable with ram_addr_q == hi_q when lo == hi: the single word is checked in
        // StDrain.
        if (ram_addr_q == hi_q) begin
          state_d = StDrain;
        end else begin
          check_en   = 1'b1;
          ram_addr_d = addr_inc;
          if (addr_inc == hi_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        check_en = 1'b1;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_stats) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (word_err) begin
      if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (!push) begin
        ovf_d = 1'b1;
      end
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ram_addr_q <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PtrW-1:0]] <= ram_addr_q;
      fifo_kind_q[wr_ptr_q[PtrW-1:0]] <= {addr_err, parity_err};
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_we       = 1'b1;
  assign ram_data_in  = '0;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_count    = cnt_q;
  assign err_valid    = ~fifo_empty;
  assign err_addr     = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q[PtrW-1:0]];
  assign err_kind     = fifo_empty ? 2'b00 : fifo_kind_q[rd_ptr_q[PtrW-1:0]];
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_ram_parity_scrubber.sv
// Directed bench for ram_parity_scrubber with a behavioural falling-edge RAM and fault injection
// on parity and address echo.
module tb_ram_parity_scrubber;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] lo_addr;
  logic [7:0] hi_addr;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_data_in;
  logic [8:0] ram_data_out;
  logic [7:0] ram_addr_out;
  logic       busy;
  logic       done;
  logic [7:0] err_count;
  logic       err_valid;
  logic [7:0] err_addr;
  logic [1:0] err_kind;
  logic       err_pop;
  logic       err_overflow;

  logic [8:0] mem      [256];
  logic       echo_bad [256];

  int n_cmp = 0;
  int n_err = 0;

  ram_parity_scrubber #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .CNT_WIDTH (8),
    .ERR_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lo_addr     (lo_addr),
    .hi_addr     (hi_addr),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_addr_out(ram_addr_out),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_kind    (err_kind),
    .err_pop     (err_pop),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // RAM registers its address on the falling edge; a flagged address returns a corrupted echo.
  always @(negedge clk) begin
    ram_data_out <= mem[ram_addr];
    ram_addr_out <= echo_bad[ram_addr] ? (ram_addr ^ 8'h80) : ram_addr;
  end

  function automatic logic [8:0] good_word(input logic [7:0] a);
    logic [7:0] d;
    d = a ^ 8'hA5;
    return {d, ^d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    err_pop = 1'b1;
    tick();
    err_pop = 1'b0;
  endtask

  task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi, output int ncyc,
                           output logic got_done);
    lo_addr = lo;
    hi_addr = hi;
    start   = 1'b1;
    tick();
    start = 1'b0;
    ncyc  = 0;
    while (busy && ncyc < 2000) begin
      ncyc++;
      tick();
    end
    got_done = done;
  endtask

  int   ncyc;
  logic got_done;
  logic saw_done;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]      = good_word(8'(i));
      echo_bad[i] = 1'b0;
    end
    reset   = 1'b1;
    start   = 1'b0;
    lo_addr = '0;
    hi_addr = '0;
    err_pop = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_ram_addr", ram_addr, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_count", err_count, 8'h00);
    check("rst_err_valid", err_valid, 1'b0);
    check("rst_err_addr", err_addr, 8'h00);
    check("rst_err_kind", err_kind, 2'b00);
    check("rst_err_overflow", err_overflow, 1'b0);
    check("ram_we_tied", ram_we, 1'b1);
    check("ram_data_in_tied", ram_data_in, 8'h00);

    // Clean full-range sweep
    run_sweep(8'h00, 8'hFF, ncyc, got_done);
    check("clean_busy_cycles", ncyc, 256);
    check("clean_done", got_done, 1'b1);
    check("clean_count", err_count, 8'h00);
    check("clean_valid", err_valid, 1'b0);
    tick();
    check("clean_done_pulse", done, 1'b0);

    // Single parity fault
    mem[8'h10] = good_word(8'h10) ^ 9'h001;
    run_sweep(8'h00, 8'h20, ncyc, got_done);
    check("par_busy_cycles", ncyc, 33);
    check("par_count", err_count, 8'h01);
    check("par_valid", err_valid, 1'b1);
    check("par_addr", err_addr, 8'h10);
    check("par_kind", err_kind, 2'b01);
    pop_one();
    check("par_pop_valid", err_valid, 1'b0);
    pop_one();
    check("pop_empty_ignored", err_valid, 1'b0);
    mem[8'h10] = good_word(8'h10);

    // Wrapping sweep FE..01
    mem[8'hFF] = good_word(8'hFF) ^ 9'h100;
    mem[8'h00] = good_word(8'h00) ^ 9'h001;
    run_sweep(8'hFE, 8'h01, ncyc, got_done);
    check("wrap_busy_cycles", ncyc, 4);
    check("wrap_done", got_done, 1'b1);
    check("wrap_count", err_count, 8'h02);
    check("wrap_head0", err_addr, 8'hFF);
    pop_one();
    check("wrap_head1", err_addr, 8'h00);
    pop_one();
    check("wrap_empty", err_valid, 1'b0);
    mem[8'hFF] = good_word(8'hFF);
    mem[8'h00] = good_word(8'h00);

    // Six faults into a four-deep queue
    for (int i = 8'h30; i <= 8'h35; i++) mem[i] = good_word(8'(i)) ^ 9'h001;
    run_sweep(8'h2E, 8'h38, ncyc, got_done);
    check("ovf_busy_cycles", ncyc, 11);
    check("ovf_count", err_count, 8'h06);
    check("ovf_flag", err_overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_head", err_addr, 32'h30 + 32'(i));
      pop_one();
    end
    check("ovf_drained", err_valid, 1'b0);
    check("ovf_sticky", err_overflow, 1'b1);
    for (int i = 8'h30; i <= 8'h35; i++) mem[i] = good_word(8'(i));
    run_sweep(8'h40, 8'h41, ncyc, got_done);
    check("restart_ovf_clr", err_overflow, 1'b0);
    check("restart_count_clr", err_count, 8'h00);

    // Echo fault alone, then echo and parity on the same word
    echo_bad[8'h05] = 1'b1;
    echo_bad[8'h07] = 1'b1;
    mem[8'h07]      = good_word(8'h07) ^ 9'h001;
    run_sweep(8'h00, 8'h08, ncyc, got_done);
    check("echo_count", err_count, 8'h02);
    check("echo_addr", err_addr, 8'h05);
    check("echo_kind", err_kind, 2'b10);
    pop_one();
    check("both_addr", err_addr, 8'h07);
    check("both_kind", err_kind, 2'b11);
    pop_one();
    echo_bad[8'h05] = 1'b0;
    echo_bad[8'h07] = 1'b0;
    mem[8'h07]      = good_word(8'h07);

    // lo == hi checks exactly one word
    mem[8'h50] = good_word(8'h50) ^ 9'h001;
    run_sweep(8'h50, 8'h50, ncyc, got_done);
    check("single_busy_cycles", ncyc, 2);
    check("single_done", got_done, 1'b1);
    check("single_count", err_count, 8'h01);
    check("single_addr", err_addr, 8'h50);
    pop_one();
    mem[8'h50] = good_word(8'h50);

    // Every word bad: counter saturates
    for (int i = 0; i < 256; i++) mem[i] = good_word(8'(i)) ^ 9'h001;
    run_sweep(8'h00, 8'hFF, ncyc, got_done);
    check("sat_count", err_count, 8'hFF);
    check("sat_ovf", err_overflow, 1'b1);
    check("sat_head", err_addr, 8'h00);
    for (int i = 0; i < 4; i++) pop_one();
    check("sat_drained", err_valid, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = good_word(8'(i));

    // Start while busy is ignored
    lo_addr = 8'h00;
    hi_addr = 8'h0F;
    start   = 1'b1;
    tick();
    start = 1'b0;
    ncyc  = 0;
    while (busy && ncyc < 2000) begin
      if (ncyc == 4) begin
        lo_addr = 8'h80;
        hi_addr = 8'h90;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      ncyc++;
      tick();
    end
    start = 1'b0;
    check("busy_start_cycles", ncyc, 16);
    check("busy_start_done", done, 1'b1);
    check("busy_start_last_addr", ram_addr, 8'h0F);

    // Reset mid-sweep at address 0x40
    mem[8'h20] = good_word(8'h20) ^ 9'h001;
    lo_addr    = 8'h00;
    hi_addr    = 8'h80;
    start      = 1'b1;
    tick();
    start = 1'b0;
    ncyc  = 0;
    while (ram_addr != 8'h40 && ncyc < 200) begin
      ncyc++;
      tick();
    end
    check("midrst_reached_40", ram_addr, 8'h40);
    check("midrst_count_before", err_count, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", err_count, 8'h00);
    check("midrst_valid", err_valid, 1'b0);
    check("midrst_ram_addr", ram_addr, 8'h00);
    saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("midrst_no_done", saw_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
